// File: rtl/ql_ser_pkg.sv
// Shared definitions for the QL SER1/SER2 serial ports: receiver FSM states,
// the ZX8302 baud table, the divisor computation and the bit-vote helper.
package ql_ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_e;

    localparam int unsigned BAUD_TABLE [8] = '{
        32'd19200, 32'd9600, 32'd4800, 32'd2400,
        32'd1200,  32'd600,  32'd300,  32'd75
    };

    localparam int unsigned DIV_W = 32'd15;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                  input logic [2:0] sel);
        int unsigned baud_v;
        baud_v = BAUD_TABLE[sel];
        return DIV_W'((clk_hz + 32'd8 * baud_v) / (32'd16 * baud_v));
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/ql_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO completes only when a pop happens on the same clock.
module ql_fifo_sync #(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned DEPTH = 32'd8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wptr_r == rptr_r);
    assign full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full_s || pop);
    assign drop      = push && full_s && !pop;
    assign dout      = mem_r[rptr_r[AW-1:0]];
    assign level     = wptr_r - rptr_r;

    // Storage array write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= din;
        end
    end

    // Read and write pointer update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + (AW+1)'(1'b1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + (AW+1)'(1'b1);
            end
        end
    end

endmodule

// File: rtl/ql_ser_rx.sv
// QL SER1/SER2 8N1 receiver: input synchronizer, 16x tick generator,
// majority-vote frame FSM and an FWFT receive FIFO.
module ql_ser_rx
    import ql_ser_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 32'd21000000,
    parameter int unsigned FIFO_DEPTH = 32'd8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [2:0]                    baud_sel,
    input  logic                          rxd,
    input  logic                          rd,
    input  logic                          err_clr,
    output logic [7:0]                    dout,
    output logic                          avail,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic             fall_s;
    logic [2:0]       baud_q_r;
    logic             baud_chg_s;
    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] tick_cnt_r;
    logic             tick_s;
    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [3:0]       os_r;
    logic [3:0]       os_nxt_s;
    logic [1:0]       samp_r;
    logic [1:0]       samp_nxt_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic             at9_s;
    logic             vote_s;
    logic             push_s;
    logic             ferr_set_s;
    logic             fifo_empty_s;
    logic             drop_s;
    logic             frame_err_r;
    logic             overrun_r;
    logic             busy_r;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Divisor lookup; every arm folds to a constant
    always_comb begin
        case (baud_sel)
            3'd0:    div_s = baud_div(CLK_HZ, 3'd0);
            3'd1:    div_s = baud_div(CLK_HZ, 3'd1);
            3'd2:    div_s = baud_div(CLK_HZ, 3'd2);
            3'd3:    div_s = baud_div(CLK_HZ, 3'd3);
            3'd4:    div_s = baud_div(CLK_HZ, 3'd4);
            3'd5:    div_s = baud_div(CLK_HZ, 3'd5);
            3'd6:    div_s = baud_div(CLK_HZ, 3'd6);
            3'd7:    div_s = baud_div(CLK_HZ, 3'd7);
            default: div_s = baud_div(CLK_HZ, 3'd0);
        endcase
    end

    assign baud_chg_s = (baud_sel != baud_q_r);
    assign tick_s     = (tick_cnt_r == DIV_W'(0)) && !baud_chg_s;

    // Oversample tick down-counter, reloaded on wrap or rate change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_q_r   <= 3'd0;
            tick_cnt_r <= '0;
        end else begin
            baud_q_r <= baud_sel;
            if (baud_chg_s || (tick_cnt_r == DIV_W'(0))) begin
                tick_cnt_r <= div_s - DIV_W'(1);
            end else begin
                tick_cnt_r <= tick_cnt_r - DIV_W'(1);
            end
        end
    end

    // Oversample position within the bit and the first two vote samples
    always_comb begin
        os_nxt_s   = os_r;
        samp_nxt_s = samp_r;
        if (state_r == ST_IDLE) begin
            os_nxt_s = 4'd0;
        end else if (tick_s) begin
            os_nxt_s = os_r + 4'd1;
            if (os_r == 4'd7) begin
                samp_nxt_s[1] = rx_sync_r;
            end else if (os_r == 4'd8) begin
                samp_nxt_s[0] = rx_sync_r;
            end else begin
                samp_nxt_s = samp_r;
            end
        end else begin
            os_nxt_s = os_r;
        end
    end

    assign at9_s  = tick_s && (os_r == 4'd9);
    assign vote_s = maj3({samp_r, rx_sync_r});

    // Frame FSM next state, data shift and push/error strobes
    always_comb begin
        state_nxt_s = state_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        push_s      = 1'b0;
        ferr_set_s  = 1'b0;
        if (baud_chg_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        bit_nxt_s   = 3'd0;
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (at9_s) begin
                        state_nxt_s = vote_s ? ST_IDLE : ST_DATA;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (at9_s) begin
                        shift_nxt_s = {vote_s, shift_r[7:1]};
                        bit_nxt_s   = bit_r + 3'd1;
                        state_nxt_s = (bit_r == 3'd7) ? ST_STOP : ST_DATA;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (at9_s) begin
                        if (vote_s) begin
                            push_s      = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            ferr_set_s  = 1'b1;
                            state_nxt_s = ST_BRK;
                        end
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                // Hold here through a break so it yields one error, not a stream of 0x00
                ST_BRK: begin
                    if (rx_sync_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BRK;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            os_r    <= 4'd0;
            samp_r  <= 2'b11;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            os_r    <= os_nxt_s;
            samp_r  <= samp_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr) begin
                frame_err_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (err_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    ql_fifo_sync #(
        .WIDTH (32'd8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .din     (shift_r),
        .pop     (rd),
        .dout    (dout),
        .empty   (fifo_empty_s),
        .level   (level),
        .drop    (drop_s)
    );

    assign avail     = !fifo_empty_s;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

endmodule
